// File: rtl/hex_digit_scanner_pkg.sv
// hex_digit_scanner_pkg: shared FSM encodings and anode polarity for the hex digit scanner
package hex_digit_scanner_pkg;
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;
  localparam logic DIGIT_OFF = 1'b1;
endpackage

// File: rtl/hex_digit_scanner_if.sv
// hex_digit_scanner_if: value/strobe inputs and display outputs of the hex digit scanner
interface hex_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    lzb_en;
  logic [3:0]              x;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;
  logic                    update_pending;
  modport master (
    output value, load, lzb_en,
    input  x, digit_en, frame_done, update_pending
  );
  modport slave (
    input  value, load, lzb_en,
    output x, digit_en, frame_done, update_pending
  );
endinterface

// File: rtl/hex_digit_scanner_slot_timer.sv
// slot_timer: slot counter, digit index and blank/show FSM; exposes current and next-cycle timing flags
module slot_timer
  import hex_digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(NUM_DIGITS)-1:0] idx_nxt_o,
  output logic                          in_blank_o,
  output logic                          slot_last_o,
  output logic                          frame_last_o,
  output logic                          frame_last_nxt_o
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  state_t        st_q, st_d;
  logic          slot_last, idx_last;
  // Next-state for counter, digit index and blank/show phase
  always_comb begin
    slot_last = cnt_q == CW'(TICK_DIV - 1);
    idx_last  = idx_q == IW'(NUM_DIGITS - 1);
    cnt_d     = slot_last ? '0 : cnt_q + CW'(1);
    idx_d     = slot_last ? (idx_last ? '0 : idx_q + IW'(1)) : idx_q;
    st_d      = (st_q == ST_BLANK) ? ((cnt_q == CW'(BLANK_CYCLES - 1)) ? ST_SHOW : ST_BLANK)
                                   : (slot_last ? ST_BLANK : ST_SHOW);
  end
  // Timing state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      st_q  <= ST_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      st_q  <= st_d;
    end
  end
  // Output registers downstream load from the _nxt flags so they line up with the cycle they describe
  assign idx_nxt_o        = idx_d;
  assign in_blank_o       = st_d == ST_BLANK;
  assign slot_last_o      = slot_last;
  assign frame_last_o     = slot_last && idx_last;
  assign frame_last_nxt_o = (cnt_d == CW'(TICK_DIV - 1)) && (idx_d == IW'(NUM_DIGITS - 1));
endmodule

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: time-multiplexed N-digit hex display driver with frame-synchronous updates
module hex_digit_scanner
  import hex_digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  hex_digit_scanner_if.slave bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  logic [W-1:0]          shadow_q, shadow_d, disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [3:0]            x_q, x_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d, lz;
  logic                  frame_done_q;
  logic                  nz;
  logic [IW-1:0]         idx_nxt;
  logic                  in_blank, slot_last, frame_last, frame_last_nxt;
  slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .idx_nxt_o       (idx_nxt),
    .in_blank_o      (in_blank),
    .slot_last_o     (slot_last),
    .frame_last_o    (frame_last),
    .frame_last_nxt_o(frame_last_nxt)
  );
  // Shadow capture and frame-end commit; a load landing on the commit cycle goes straight to disp
  always_comb begin
    shadow_d  = bus.load ? bus.value : shadow_q;
    disp_d    = frame_last ? (bus.load ? bus.value : (pending_q ? shadow_q : disp_q)) : disp_q;
    pending_d = frame_last ? 1'b0 : (bus.load | pending_q);
  end
  // Leading-zero mask, digit nibble and anode select for the upcoming cycle
  always_comb begin
    nz = 1'b0;
    lz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz    = nz | (disp_d[4*i +: 4] != 4'h0);
      lz[i] = bus.lzb_en && !nz && (i != 0);
    end
    x_d                 = slot_last ? disp_d[{idx_nxt, 2'b00} +: 4] : x_q;
    digit_en_d          = {NUM_DIGITS{DIGIT_OFF}};
    digit_en_d[idx_nxt] = (in_blank || lz[idx_nxt]) ? DIGIT_OFF : ~DIGIT_OFF;
  end
  // Value storage and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      x_q          <= '0;
      digit_en_q   <= {NUM_DIGITS{DIGIT_OFF}};
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      x_q          <= x_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_last_nxt;
    end
  end
  assign bus.x              = x_q;
  assign bus.digit_en       = digit_en_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.update_pending = pending_q;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb_hex_digit_scanner: directed checks of scan order, blanking, frame-synchronous updates and reset
module tb_hex_digit_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   p;
  int   vecs = 0;
  int   miss = 0;
  logic [3:0] sx [4];
  logic [3:0] se [4];

  hex_digit_scanner_if #(.NUM_DIGITS(4)) bus ();

  hex_digit_scanner #(
    .NUM_DIGITS  (4),
    .TICK_DIV    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Independent position counter: cycles elapsed since reset release
  always @(posedge clk or posedge rst) p <= rst ? 0 : p + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    int g = 0;
    while (p < t && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (p != t) begin
      miss++;
      $error("FAIL goto: reached position %0d expected %0d", p, t);
    end
  endtask

  task automatic ld(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  initial begin
    sx = '{4'hF, 4'h2, 4'hA, 4'h1};
    se = '{4'hE, 4'hD, 4'hB, 4'h7};
    bus.value  = '0;
    bus.load   = 1'b0;
    bus.lzb_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", bus.digit_en, 4'hF);
    chk("rst_x", bus.x, 4'h0);
    chk("rst_fd", bus.frame_done, 1'b0);
    chk("rst_up", bus.update_pending, 1'b0);
    rst = 1'b0;
    chk("c0_en", bus.digit_en, 4'hF);
    goto(1);
    chk("c1_en", bus.digit_en, 4'hF);
    goto(2);
    chk("c2_en", bus.digit_en, 4'hE);
    chk("c2_x", bus.x, 4'h0);
    ld(16'h1A2F);
    chk("ld_up", bus.update_pending, 1'b1);
    goto(10);
    chk("old_en", bus.digit_en, 4'hD);
    chk("old_x", bus.x, 4'h0);
    goto(30);
    chk("fd_30", bus.frame_done, 1'b0);
    goto(31);
    chk("fd_31", bus.frame_done, 1'b1);
    chk("up_31", bus.update_pending, 1'b1);
    for (int k = 0; k < 32; k++) begin
      goto(32 + k);
      chk("scan_x", bus.x, sx[k/8]);
      chk("scan_en", bus.digit_en, (k % 8 < 2) ? 4'hF : se[k/8]);
      chk("scan_fd", bus.frame_done, k == 31);
    end
    chk("scan_up", bus.update_pending, 1'b0);
    goto(69);
    ld(16'h1234);
    chk("tf_up", bus.update_pending, 1'b1);
    chk("tf_x_old", bus.x, 4'hF);
    goto(80);
    chk("tf_x_old2", bus.x, 4'hA);
    goto(95);
    chk("tf_fd", bus.frame_done, 1'b1);
    chk("tf_x_old3", bus.x, 4'h1);
    chk("tf_up_hold", bus.update_pending, 1'b1);
    goto(96);
    chk("tf_x0", bus.x, 4'h4);
    chk("tf_en_blank", bus.digit_en, 4'hF);
    chk("tf_up_drop", bus.update_pending, 1'b0);
    goto(98);
    chk("tf_en0", bus.digit_en, 4'hE);
    chk("tf_x0b", bus.x, 4'h4);
    goto(106);
    chk("tf_x1", bus.x, 4'h3);
    chk("tf_en1", bus.digit_en, 4'hD);
    goto(114);
    chk("tf_x2", bus.x, 4'h2);
    chk("tf_en2", bus.digit_en, 4'hB);
    goto(122);
    chk("tf_x3", bus.x, 4'h1);
    chk("tf_en3", bus.digit_en, 4'h7);
    goto(127);
    chk("sim_fd", bus.frame_done, 1'b1);
    chk("sim_up0", bus.update_pending, 1'b0);
    ld(16'hBEEF);
    chk("sim_up", bus.update_pending, 1'b0);
    chk("sim_x0", bus.x, 4'hF);
    chk("sim_en0", bus.digit_en, 4'hF);
    goto(136);
    chk("sim_x1", bus.x, 4'hE);
    goto(144);
    chk("sim_x2", bus.x, 4'hE);
    goto(154);
    chk("sim_x3", bus.x, 4'hB);
    chk("sim_en3", bus.digit_en, 4'h7);
    chk("sim_up2", bus.update_pending, 1'b0);
    bus.lzb_en = 1'b1;
    goto(156);
    ld(16'h0050);
    goto(162);
    chk("lz_en0", bus.digit_en, 4'hE);
    chk("lz_x0", bus.x, 4'h0);
    goto(170);
    chk("lz_en1", bus.digit_en, 4'hD);
    chk("lz_x1", bus.x, 4'h5);
    ld(16'h0000);
    goto(178);
    chk("lz_en2", bus.digit_en, 4'hF);
    chk("lz_x2", bus.x, 4'h0);
    goto(183);
    chk("lz_en2_end", bus.digit_en, 4'hF);
    goto(186);
    chk("lz_en3", bus.digit_en, 4'hF);
    goto(191);
    chk("lz_en3_end", bus.digit_en, 4'hF);
    chk("lz_fd", bus.frame_done, 1'b1);
    goto(194);
    chk("z_en0", bus.digit_en, 4'hE);
    chk("z_x0", bus.x, 4'h0);
    goto(202);
    chk("z_en1", bus.digit_en, 4'hF);
    goto(210);
    chk("z_en2", bus.digit_en, 4'hF);
    goto(218);
    chk("z_en3", bus.digit_en, 4'hF);
    goto(220);
    chk("z_en3_late", bus.digit_en, 4'hF);
    bus.lzb_en = 1'b0;
    goto(221);
    chk("nolz_en3", bus.digit_en, 4'h7);
    goto(226);
    chk("nolz_en0", bus.digit_en, 4'hE);
    goto(234);
    chk("nolz_en1", bus.digit_en, 4'hD);
    goto(242);
    chk("nolz_en2", bus.digit_en, 4'hB);
    goto(258);
    ld(16'h1111);
    chk("b2b_up", bus.update_pending, 1'b1);
    goto(262);
    ld(16'h2222);
    goto(287);
    chk("b2b_fd", bus.frame_done, 1'b1);
    goto(288);
    chk("b2b_up_drop", bus.update_pending, 1'b0);
    chk("b2b_x0", bus.x, 4'h2);
    goto(290);
    chk("b2b_en0", bus.digit_en, 4'hE);
    goto(298);
    chk("b2b_x1", bus.x, 4'h2);
    chk("b2b_en1", bus.digit_en, 4'hD);
    goto(306);
    chk("b2b_x2", bus.x, 4'h2);
    goto(314);
    chk("b2b_x3", bus.x, 4'h2);
    chk("b2b_en3", bus.digit_en, 4'h7);
    goto(319);
    chk("b2b_fd2", bus.frame_done, 1'b1);
    goto(320);
    chk("b2b_up2", bus.update_pending, 1'b0);
    chk("b2b_x_next", bus.x, 4'h2);
    goto(322);
    ld(16'h3333);
    chk("mr_up", bus.update_pending, 1'b1);
    goto(325);
    chk("mr_show", bus.digit_en, 4'hE);
    rst = 1'b1;
    #1;
    chk("mr_en", bus.digit_en, 4'hF);
    chk("mr_x", bus.x, 4'h0);
    chk("mr_fd", bus.frame_done, 1'b0);
    chk("mr_up_clr", bus.update_pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_c0_en", bus.digit_en, 4'hF);
    goto(2);
    chk("mr_c2_en", bus.digit_en, 4'hE);
    chk("mr_c2_x", bus.x, 4'h0);
    goto(34);
    chk("mr_lost_x", bus.x, 4'h0);
    chk("mr_lost_en", bus.digit_en, 4'hE);
    chk("mr_lost_up", bus.update_pending, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
